// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, one-hot class indices, instruction field
// positions and the decoded record stored in the instruction queue.
package decode_pkg;

  localparam int NUM_CLASS = 11;
  // Wide enough for any supported DATA_W / PC_W; the queue truncates on read.
  localparam int DEC_MAX_W = 64;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int CLS_ALU  = 0;
  localparam int CLS_ADDI = 1;
  localparam int CLS_J    = 2;
  localparam int CLS_BNE  = 3;
  localparam int CLS_JAL  = 4;
  localparam int CLS_JR   = 5;
  localparam int CLS_BLT  = 6;
  localparam int CLS_SW   = 7;
  localparam int CLS_LW   = 8;
  localparam int CLS_BEX  = 9;
  localparam int CLS_SETX = 10;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int SHAMT_HI = 11;
  localparam int SHAMT_LO = 7;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;
  localparam int IMM_HI   = 16;
  localparam int TGT_HI   = 26;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  typedef struct packed {
    logic [NUM_CLASS-1:0] cls;
    logic                 illegal;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           aluop;
    logic [4:0]           shamt;
    logic [DEC_MAX_W-1:0] imm;
    logic [DEC_MAX_W-1:0] target;
    logic [DEC_MAX_W-1:0] pc;
  } decoded_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction decoder: one instruction word plus PC in, one
// fully decoded record out.
module instr_field_decode
  import decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output decoded_t           dec_o
);

  logic [4:0] opc, rd, rs, rt;

  assign opc = instr_i[OPC_HI:OPC_LO];
  assign rd  = instr_i[RD_HI:RD_LO];
  assign rs  = instr_i[RS_HI:RS_LO];
  assign rt  = instr_i[RT_HI:RT_LO];

  always_comb begin
    dec_o        = '0;
    dec_o.aluop  = instr_i[ALUOP_HI:ALUOP_LO];
    dec_o.shamt  = instr_i[SHAMT_HI:SHAMT_LO];
    dec_o.imm    = {{(DEC_MAX_W-IMM_HI-1){instr_i[IMM_HI]}}, instr_i[IMM_HI:0]};
    dec_o.target = {{(DEC_MAX_W-TGT_HI-1){1'b0}}, instr_i[TGT_HI:0]};
    dec_o.pc     = DEC_MAX_W'(pc_i);
    case (opc)
      OP_ALU: begin
        dec_o.cls[CLS_ALU] = 1'b1;
        dec_o.rs1          = rs;
        dec_o.rs2          = rt;
        dec_o.wr_en        = (rd != 5'd0);
        dec_o.wr_addr      = rd;
      end
      OP_ADDI: begin
        dec_o.cls[CLS_ADDI] = 1'b1;
        dec_o.rs1           = rs;
        dec_o.wr_en         = (rd != 5'd0);
        dec_o.wr_addr       = rd;
      end
      OP_LW: begin
        dec_o.cls[CLS_LW] = 1'b1;
        dec_o.rs1         = rs;
        dec_o.wr_en       = (rd != 5'd0);
        dec_o.wr_addr     = rd;
      end
      OP_SW: begin
        dec_o.cls[CLS_SW] = 1'b1;
        dec_o.rs1         = rs;
        dec_o.rs2         = rd;
      end
      OP_BNE: begin
        dec_o.cls[CLS_BNE] = 1'b1;
        dec_o.rs1          = rd;
        dec_o.rs2          = rs;
      end
      OP_BLT: begin
        dec_o.cls[CLS_BLT] = 1'b1;
        dec_o.rs1          = rd;
        dec_o.rs2          = rs;
      end
      OP_JR: begin
        dec_o.cls[CLS_JR] = 1'b1;
        dec_o.rs1         = rd;
      end
      OP_J:   dec_o.cls[CLS_J] = 1'b1;
      OP_JAL: begin
        dec_o.cls[CLS_JAL] = 1'b1;
        dec_o.wr_en        = 1'b1;
        dec_o.wr_addr      = REG_LINK;
      end
      OP_SETX: begin
        dec_o.cls[CLS_SETX] = 1'b1;
        dec_o.wr_en         = 1'b1;
        dec_o.wr_addr       = REG_STATUS;
      end
      OP_BEX: begin
        dec_o.cls[CLS_BEX] = 1'b1;
        dec_o.rs1          = REG_STATUS;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode-then-buffer queue between fetch and execute. Optional pop statistics
// counters are built when DECODE_STATS_EN is defined.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [NUM_CLASS-1:0]       out_class,
  output logic                       out_illegal,
  output logic                       out_wr_en,
  output logic [4:0]                 out_wr_addr,
  output logic [4:0]                 out_rs1_addr,
  output logic [4:0]                 out_rs2_addr,
  output logic [4:0]                 out_aluop,
  output logic [4:0]                 out_shamt,
  output logic [DATA_W-1:0]          out_imm,
  output logic [DATA_W-1:0]          out_target,
`ifdef DECODE_STATS_EN
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_illegal,
`endif
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  decoded_t          dec, head;
  decoded_t          mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic              push, pop;

  instr_field_decode #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  assign in_ready  = (occ_q < FULL_CNT) & ~flush;
  assign out_valid = (occ_q != '0);
  assign occupancy = occ_q;
  assign push      = in_valid & in_ready;
  // Flush swallows a same-cycle pop as well as a push.
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
      else if (pop && !push) occ_d = occ_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_pc       = PC_W'(head.pc);
  assign out_class    = head.cls;
  assign out_illegal  = head.illegal;
  assign out_wr_en    = head.wr_en;
  assign out_wr_addr  = head.wr_addr;
  assign out_rs1_addr = head.rs1;
  assign out_rs2_addr = head.rs2;
  assign out_aluop    = head.aluop;
  assign out_shamt    = head.shamt;
  assign out_imm      = DATA_W'(head.imm);
  assign out_target   = DATA_W'(head.target);

`ifdef DECODE_STATS_EN
  logic [31:0] issued_q, illegal_q;

  // Survives flush; only reset clears the counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (pop) begin
      issued_q <= issued_q + 32'd1;
      if (head.illegal) illegal_q <= illegal_q + 32'd1;
    end
  end

  assign stat_issued  = issued_q;
  assign stat_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_instr_decode_queue;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int DEPTH   = 2;
  localparam int OW      = $clog2(DEPTH) + 1;

  logic               clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [10:0]        out_class;
  logic               out_illegal, out_wr_en;
  logic [4:0]         out_wr_addr, out_rs1_addr, out_rs2_addr, out_aluop, out_shamt;
  logic [DATA_W-1:0]  out_imm, out_target;
  logic [OW-1:0]      occupancy;
`ifdef DECODE_STATS_EN
  logic [31:0]        stat_issued, stat_illegal;
`endif

  instr_decode_queue #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_illegal(out_illegal), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_aluop(out_aluop), .out_shamt(out_shamt), .out_imm(out_imm), .out_target(out_target),
`ifdef DECODE_STATS_EN
    .stat_issued(stat_issued), .stat_illegal(stat_illegal),
`endif
    .occupancy(occupancy)
  );

  typedef struct {
    logic [10:0] cls;
    logic        illegal, wr_en;
    logic [4:0]  wr_addr, rs1, rs2, aluop, shamt;
    logic [31:0] imm, target, pc;
  } exp_t;

  exp_t mq[$];
  int   errors = 0, checks = 0;
  int   st_iss = 0, st_ill = 0;
  bit   m_push, m_pop;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   idx;
    logic [4:0] rd, rs, rt;
    rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    case (ins[31:27])
      5'd0: idx = 0;  5'd5: idx = 1;  5'd1: idx = 2;  5'd2: idx = 3;
      5'd3: idx = 4;  5'd4: idx = 5;  5'd6: idx = 6;  5'd7: idx = 7;
      5'd8: idx = 8;  5'd22: idx = 9; 5'd21: idx = 10;
      default: idx = -1;
    endcase
    e.cls     = (idx < 0) ? 11'd0 : (11'd1 << idx);
    e.illegal = (idx < 0);
    e.rs1 = 0; e.rs2 = 0; e.wr_en = 0; e.wr_addr = 0;
    case (idx)
      0:    begin e.rs1 = rs; e.rs2 = rt; end
      1, 8: e.rs1 = rs;
      7:    begin e.rs1 = rs; e.rs2 = rd; end
      3, 6: begin e.rs1 = rd; e.rs2 = rs; end
      5:    e.rs1 = rd;
      9:    e.rs1 = 5'd30;
      default: ;
    endcase
    if ((idx == 0 || idx == 1 || idx == 8) && rd != 0) begin e.wr_en = 1; e.wr_addr = rd; end
    if (idx == 4)  begin e.wr_en = 1; e.wr_addr = 5'd31; end
    if (idx == 10) begin e.wr_en = 1; e.wr_addr = 5'd30; end
    e.aluop  = ins[6:2];
    e.shamt  = ins[11:7];
    e.imm    = {{15{ins[16]}}, ins[16:0]};
    e.target = {5'd0, ins[26:0]};
    e.pc     = pc;
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); st_iss = 0; st_ill = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < DEPTH);
      if (m_pop) begin
        st_iss++;
        if (mq[0].illegal) st_ill++;
        void'(mq.pop_front());
      end
      if (m_push) mq.push_back(model_dec(in_instr, in_pc));
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !flush));
      if (mq.size() != 0) begin
        chk("class",   64'(out_class),    64'(mq[0].cls));
        chk("illegal", 64'(out_illegal),  64'(mq[0].illegal));
        chk("wr_en",   64'(out_wr_en),    64'(mq[0].wr_en));
        chk("wr_addr", 64'(out_wr_addr),  64'(mq[0].wr_addr));
        chk("rs1",     64'(out_rs1_addr), 64'(mq[0].rs1));
        chk("rs2",     64'(out_rs2_addr), 64'(mq[0].rs2));
        chk("shamt",   64'(out_shamt),    64'(mq[0].shamt));
        chk("imm",     64'(out_imm),      64'(mq[0].imm));
        chk("target",  64'(out_target),   64'(mq[0].target));
        chk("pc",      64'(out_pc),       64'(mq[0].pc));
        if (mq[0].cls[0]) chk("aluop", 64'(out_aluop), 64'(mq[0].aluop));
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] stream [10];

  initial begin
    stream = '{32'h21C00000, 32'h30860005, 32'h390A0008, 32'h42420010, 32'hA8000055,
               32'hB0000077, 32'hF8000000, 32'h000C7000, 32'h2FC0FFFF, 32'h0FFFFFFF};
    reset_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_class",     64'(out_class), 64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    chk("rst_imm",       64'(out_imm),   64'd0);
    chk("rst_pc",        64'(out_pc),    64'd0);
    reset_n = 1;
    tick();

    // lw r0, 0(r0)
    push1(32'h40000000, 32'h10);
    chk("lw_valid", 64'(out_valid), 64'd1);
    chk("lw_class", 64'(out_class), 64'h100);
    chk("lw_pc",    64'(out_pc),    64'h10);
    chk("lw_ready", 64'(in_ready),  64'd1);
    out_ready = 1; tick(); out_ready = 0;

    // addi r3, r2, -1 then the same with rd = r0
    push1(32'h28C5FFFF, 32'h14);
    chk("addi_imm",   64'(out_imm),      64'hFFFFFFFF);
    chk("addi_wr_en", 64'(out_wr_en),    64'd1);
    chk("addi_wr",    64'(out_wr_addr),  64'd3);
    chk("addi_rs1",   64'(out_rs1_addr), 64'd2);
    out_ready = 1; tick(); out_ready = 0;
    push1(32'h2805FFFF, 32'h18);
    chk("addi_r0_wr_en", 64'(out_wr_en), 64'd0);
    out_ready = 1; tick(); out_ready = 0;

    // Back-pressure: third instruction must be refused.
    push1(32'h014C7190, 32'h100);
    push1(32'h08001234, 32'h104);
    chk("full_in_ready", 64'(in_ready),  64'd0);
    chk("full_occ",      64'(occupancy), 64'd2);
    push1(32'h1045FFFE, 32'h108);
    chk("full_occ_hold", 64'(occupancy), 64'd2);
    chk("full_head_pc",  64'(out_pc),    64'h100);
    out_ready = 1; tick();
    chk("order_pc2",     64'(out_pc),    64'h104);
    tick(); out_ready = 0;
    chk("drained",       64'(out_valid), 64'd0);

    // Streaming push+pop at occupancy 1, wrapping pointers.
    push1(32'h18000040, 32'h200);
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_instr = stream[i]; in_pc = 32'h300 + 32'(4 * i);
      tick();
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 0; tick(); out_ready = 0;

    // Flush with a concurrent push.
    push1(32'h014C7190, 32'h400);
    push1(32'h08001234, 32'h404);
    flush = 1; in_valid = 1; in_instr = 32'h1045FFFE; in_pc = 32'h408;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ",   64'(occupancy), 64'd0);
    push1(32'h21C00000, 32'h40C);
    chk("post_flush_pc", 64'(out_pc), 64'h40C);
    out_ready = 1; tick(); out_ready = 0;

    // Reset mid-transfer.
    push1(32'h014C7190, 32'h500);
    push1(32'h08001234, 32'h504);
    #2 reset_n = 0;
    #1 chk("midrst_occ",   64'(occupancy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    #2 reset_n = 1;
    tick();

    // Illegal opcode, then four more pops for the statistics.
    push1(32'hF8000000, 32'h600);
    chk("ill_class", 64'(out_class),   64'd0);
    chk("ill_flag",  64'(out_illegal), 64'd1);
    chk("ill_wr_en", 64'(out_wr_en),   64'd0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) push1(stream[i], 32'h604 + 32'(4 * i));
    repeat (2) tick();
    out_ready = 0;
`ifdef DECODE_STATS_EN
    chk("stat_issued",  64'(stat_issued),  64'd5);
    chk("stat_illegal", 64'(stat_illegal), 64'd1);
    chk("stat_model",   64'(stat_issued),  64'(st_iss));
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
